// File: rtl/hamming_code_7bit.sv
// hamming_code_7bit
// Registered Hamming(7,4) single-error-correcting decoder.
// The syndrome of D is computed combinationally.
// The corrected codeword, data nibble, syndrome and error flag are registered
// one clock after an enabled capture.
// Bit index of D and O equals the Hamming position: parity at 1, 2 and 4,
// data at 3, 5, 6 and 7.
// Build option: define HAMMING_ERR_CNT_EN to include the saturating
// corrected-word counter. Otherwise err_cnt is tied to zero.
module hamming_code_7bit (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:1] D,
   input  logic       EN,
   output logic [7:1] O,
   output logic       Error,
   output logic [2:0] syndrome,
   output logic [3:0] data,
   output logic       valid,
   output logic [7:0] err_cnt
);

   logic [2:0] syn_next;
   logic [7:1] flip_mask;
   logic [7:1] corr_next;
   logic [3:0] data_next;
   logic       error_next;

   logic [7:1] o_reg;
   logic       error_reg;
   logic [2:0] syndrome_reg;
   logic [3:0] data_reg;
   logic       valid_reg;

   // Syndrome bits; each one covers the positions whose index has that bit set.
   always_comb begin
      syn_next    = 3'd0;
      syn_next[0] = D[1] ^ D[3] ^ D[5] ^ D[7];
      syn_next[1] = D[2] ^ D[3] ^ D[6] ^ D[7];
      syn_next[2] = D[4] ^ D[5] ^ D[6] ^ D[7];
   end

   // One-hot flip mask: position gi is inverted when the syndrome names it.
   // A zero syndrome matches no position, so a clean word passes through.
   genvar gi;
   generate
      for (gi = 1; gi <= 7; gi++) begin : g_flip
         localparam logic [2:0] POS = 3'(gi);
         assign flip_mask[gi] = (syn_next == POS);
      end
   endgenerate

   // Build the corrected word, the extracted data nibble and the error flag.
   // Double-bit errors are knowingly miscorrected at position S.
   always_comb begin
      corr_next  = D ^ flip_mask;
      data_next  = {corr_next[7], corr_next[6], corr_next[5], corr_next[3]};
      error_next = (syn_next != 3'd0);
   end

   // Output register: load the decode when enabled, hold otherwise.
   // valid marks only the cycle after a capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_reg        <= 7'd0;
         error_reg    <= 1'b0;
         syndrome_reg <= 3'd0;
         data_reg     <= 4'd0;
         valid_reg    <= 1'b0;
      end else begin
         valid_reg <= EN;
         if (EN) begin
            o_reg        <= corr_next;
            error_reg    <= error_next;
            syndrome_reg <= syn_next;
            data_reg     <= data_next;
         end
      end
   end

`ifdef HAMMING_ERR_CNT_EN
   logic [7:0] cnt_reg;

   // Count corrected words on the same edge that loads Error; stick at 255.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= 8'd0;
      end else if (EN && error_next && (cnt_reg != 8'hFF)) begin
         cnt_reg <= cnt_reg + 8'd1;
      end
   end

   assign err_cnt = cnt_reg;
`else
   assign err_cnt = 8'd0;
`endif

   assign O        = o_reg;
   assign Error    = error_reg;
   assign syndrome = syndrome_reg;
   assign data     = data_reg;
   assign valid    = valid_reg;

endmodule

// File: tb/tb_hamming_code_7bit.sv
// tb_hamming_code_7bit
// Directed bench for the registered Hamming(7,4) decoder.
// It covers reset, the hand-worked words, hold while disabled, and every
// single-bit error of all 16 codewords.
// It also covers the err_cnt behaviour: a saturating counter when
// HAMMING_ERR_CNT_EN is defined, and a constant zero otherwise.
module tb_hamming_code_7bit;

   logic       clk;
   logic       rst;
   logic [7:1] D;
   logic       EN;
   logic [7:1] O;
   logic       Error;
   logic [2:0] syndrome;
   logic [3:0] data;
   logic       valid;
   logic [7:0] err_cnt;

   int tests_run;
   int tests_failed;
   int exp_cnt;

   hamming_code_7bit dut (
      .clk      (clk),
      .rst      (rst),
      .D        (D),
      .EN       (EN),
      .O        (O),
      .Error    (Error),
      .syndrome (syndrome),
      .data     (data),
      .valid    (valid),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Encode a data nibble {d7,d6,d5,d3} into a codeword indexed by position.
   function automatic logic [7:1] enc(input logic [3:0] d);
      logic [7:1] cw;
      cw    = 7'd0;
      cw[7] = d[3];
      cw[6] = d[2];
      cw[5] = d[1];
      cw[3] = d[0];
      cw[1] = cw[3] ^ cw[5] ^ cw[7];
      cw[2] = cw[3] ^ cw[6] ^ cw[7];
      cw[4] = cw[5] ^ cw[6] ^ cw[7];
      return cw;
   endfunction

   // Drive one cycle of stimulus, then wait until just after the edge.
   // inj tells the expected-count model that the word carries an injected error.
   task automatic step(input logic [7:1] d, input logic en, input logic r, input logic inj);
      @(negedge clk);
      D   = d;
      EN  = en;
      rst = r;
      @(posedge clk);
      #1;
      if (r) exp_cnt = 0;
      else if (en && inj && exp_cnt < 255) exp_cnt++;
      $display("[TB] rst=%b EN=%b D=%b -> O=%b syn=%0d Error=%b data=%b valid=%b err_cnt=%0d",
               r, en, d, O, syndrome, Error, data, valid, err_cnt);
   endtask

   function automatic logic [7:0] exp_err_cnt();
`ifdef HAMMING_ERR_CNT_EN
      return 8'(exp_cnt);
`else
      return 8'd0;
`endif
   endfunction

   initial begin
      logic [7:1] cw;
      logic [7:1] bad;
      tests_run    = 0;
      tests_failed = 0;
      exp_cnt      = 0;
      rst = 1'b1;
      EN  = 1'b0;
      D   = 7'd0;

      // Reset for two clocks.
      repeat (2) @(posedge clk);
      #1;
      check("rst_O", O, 0);
      check("rst_Error", Error, 0);
      check("rst_syn", syndrome, 0);
      check("rst_data", data, 0);
      check("rst_valid", valid, 0);
      check("rst_cnt", err_cnt, 0);

      // Clean all-zero word.
      step(7'b0000000, 1'b1, 1'b0, 1'b0);
      check("zero_O", O, 7'b0000000);
      check("zero_Error", Error, 0);
      check("zero_syn", syndrome, 0);
      check("zero_valid", valid, 1);

      // Valid codeword.
      step(7'b0101010, 1'b1, 1'b0, 1'b0);
      check("cw_O", O, 7'b0101010);
      check("cw_Error", Error, 0);
      check("cw_syn", syndrome, 0);
      check("cw_data", data, 4'b0100);

      // Error at position 7.
      step(7'b1101010, 1'b1, 1'b0, 1'b1);
      check("p7_syn", syndrome, 3'b111);
      check("p7_O", O, 7'b0101010);
      check("p7_Error", Error, 1);
      check("p7_data", data, 4'b0100);

      // Error at position 3.
      step(7'b0101110, 1'b1, 1'b0, 1'b1);
      check("p3_syn", syndrome, 3'b011);
      check("p3_O", O, 7'b0101010);
      check("p3_Error", Error, 1);
      check("p3_cnt", err_cnt, exp_err_cnt());

      // Valid word followed by three disabled cycles that must hold it.
      step(7'b0110100, 1'b1, 1'b0, 1'b0);
      check("hv_O", O, 7'b0110100);
      check("hv_Error", Error, 0);
      check("hv_data", data, 4'b0111);
      for (int k = 0; k < 3; k++) begin
         step(7'b1111111, 1'b0, 1'b0, 1'b0);
         check("hold_O", O, 7'b0110100);
         check("hold_data", data, 4'b0111);
         check("hold_syn", syndrome, 0);
         check("hold_Error", Error, 0);
         check("hold_valid", valid, 0);
      end

      // Every single-bit error of every codeword.
      for (int v = 0; v < 16; v++) begin
         cw = enc(4'(v));
         for (int p = 1; p <= 7; p++) begin
            bad    = cw;
            bad[p] = ~bad[p];
            step(bad, 1'b1, 1'b0, 1'b1);
            check("ex_O", O, cw);
            check("ex_syn", syndrome, p);
            check("ex_Error", Error, 1);
            check("ex_data", data, v);
            check("ex_valid", valid, 1);
         end
      end
      check("ex_cnt", err_cnt, exp_err_cnt());

      // A reset on the same edge as an enabled errored word discards that word.
      step(7'b1000000, 1'b1, 1'b1, 1'b1);
      check("mid_rst_O", O, 0);
      check("mid_rst_Error", Error, 0);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_cnt", err_cnt, 0);

      // 300 consecutive errored words drive the counter into saturation.
      for (int i = 0; i < 300; i++) begin
         cw        = enc(4'(i % 16));
         bad       = cw;
         bad[1 + (i % 7)] = ~bad[1 + (i % 7)];
         step(bad, 1'b1, 1'b0, 1'b1);
         if (i == 9 || i == 253 || i == 254 || i == 299)
            check("sat_cnt", err_cnt, exp_err_cnt());
      end

      // The saturated value holds through a disabled cycle.
      step(7'b1000000, 1'b0, 1'b0, 1'b1);
      check("sat_hold", err_cnt, exp_err_cnt());

      // Reset clears the counter on the next edge.
      step(7'b0000000, 1'b0, 1'b1, 1'b0);
      check("cnt_clr", err_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
